// File: rtl/estacao_reserva_r.sv
// estacao_reserva_r
// Three-entry reservation station for a combinational R-type functional unit.
// Instructions are issued into the lowest free entry. They wait on CDB
// broadcasts for missing operands and are dispatched round-robin to the FU,
// one at a time. Each result is then held on the res_* port until the CDB
// arbiter grants it.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   issue_valid / issue_ready      new-instruction handshake
//   issue_op, issue_vj, issue_vk   opcode and operand values
//   issue_qj, issue_qk             producer tags (0 = value already valid)
//   cdb_valid, cdb_tag, cdb_data   common data bus snoop
//   fu_A, fu_B, fu_op / fu_Q       registered FU drive / combinational FU result
//   res_valid, res_tag, res_data   CDB broadcast request, held until res_grant
//   res_grant                      CDB arbiter grant
//   busy_count                     number of occupied entries
//   flush                          only when RS_R_FLUSH_EN is defined
//
// Configuration macro: RS_R_FLUSH_EN adds the flush input. When it is
// undefined, the block behaves as if flush were tied low.
// Parameter BASE_TAG: entry i owns tag BASE_TAG+i. It must be nonzero, and
// BASE_TAG+2 must not exceed 7.

module estacao_reserva_r #(
    parameter int unsigned BASE_TAG = 1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef RS_R_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [2:0]  issue_op,
    input  logic [15:0] issue_vj,
    input  logic [15:0] issue_vk,
    input  logic [2:0]  issue_qj,
    input  logic [2:0]  issue_qk,
    input  logic        cdb_valid,
    input  logic [2:0]  cdb_tag,
    input  logic [15:0] cdb_data,
    output logic [15:0] fu_A,
    output logic [15:0] fu_B,
    output logic [2:0]  fu_op,
    input  logic [15:0] fu_Q,
    output logic        res_valid,
    output logic [2:0]  res_tag,
    output logic [15:0] res_data,
    input  logic        res_grant,
    output logic [1:0]  busy_count
);

    localparam int unsigned NUM_ENT = 3;
    localparam int unsigned DW      = 16;
    localparam int unsigned TW      = 3;
    localparam int unsigned OPW     = 3;
    localparam int unsigned IDXW    = 2;
    localparam int unsigned CW      = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    // Scheduler state
    state_t            state_q, state_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [IDXW-1:0]   cur_q, cur_d;

    // Entry storage
    logic [NUM_ENT-1:0] busy_q, busy_d;
    logic [OPW-1:0]     op_q [NUM_ENT];
    logic [OPW-1:0]     op_d [NUM_ENT];
    logic [DW-1:0]      vj_q [NUM_ENT];
    logic [DW-1:0]      vj_d [NUM_ENT];
    logic [DW-1:0]      vk_q [NUM_ENT];
    logic [DW-1:0]      vk_d [NUM_ENT];
    logic [TW-1:0]      qj_q [NUM_ENT];
    logic [TW-1:0]      qj_d [NUM_ENT];
    logic [TW-1:0]      qk_q [NUM_ENT];
    logic [TW-1:0]      qk_d [NUM_ENT];

    // Output registers
    logic [DW-1:0]     fu_a_q, fu_a_d;
    logic [DW-1:0]     fu_b_q, fu_b_d;
    logic [OPW-1:0]    fu_op_q, fu_op_d;
    logic              res_valid_q, res_valid_d;
    logic [TW-1:0]     res_tag_q, res_tag_d;
    logic [DW-1:0]     res_data_q, res_data_d;
    logic [CW-1:0]     busy_count_q, busy_count_d;
    logic              issue_ready_q, issue_ready_d;

    // Combinational helpers
    logic              flush_c;
    logic              release_c;
    logic              issue_fire_c;
    logic              cdb_hit_c;
    logic [IDXW-1:0]   alloc_idx_c;
    logic [NUM_ENT-1:0] ready_c;
    logic              sel_found_c;
    logic [IDXW-1:0]   sel_idx_c;

`ifdef RS_R_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // issue_ready_q always mirrors "some registered busy bit is clear".
    assign issue_fire_c = issue_valid && issue_ready_q && !flush_c;
    assign cdb_hit_c    = cdb_valid && (cdb_tag != '0);

    // Lowest-index free entry
    always_comb begin
        alloc_idx_c = '0;
        for (int i = int'(NUM_ENT) - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_idx_c = IDXW'(i);
            end
        end
    end

    // Readiness: ops 100/101 only consume Vk, so their Qj is not waited on
    always_comb begin
        ready_c = '0;
        for (int i = 0; i < int'(NUM_ENT); i++) begin
            ready_c[i] = busy_q[i] && (qk_q[i] == '0) &&
                         ((qj_q[i] == '0) || (op_q[i][2:1] == 2'b10));
        end
    end

    // Round-robin pick. The search starts one past the last dispatched index.
    // Candidates are scanned from farthest to nearest, so the nearest ready
    // entry wins.
    always_comb begin
        int cand;
        cand        = 0;
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        for (int k = int'(NUM_ENT); k >= 1; k--) begin
            cand = int'(rr_q) + k;
            if (cand >= int'(NUM_ENT)) begin
                cand = cand - int'(NUM_ENT);
            end
            if (ready_c[IDXW'(cand)]) begin
                sel_found_c = 1'b1;
                sel_idx_c   = IDXW'(cand);
            end
        end
    end

    // Entry next-state: snoop, release, issue (with bypass), flush
    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        qj_d   = qj_q;
        qk_d   = qk_q;

        if (cdb_hit_c) begin
            for (int i = 0; i < int'(NUM_ENT); i++) begin
                if (busy_q[i] && (qj_q[i] == cdb_tag)) begin
                    vj_d[i] = cdb_data;
                    qj_d[i] = '0;
                end
                if (busy_q[i] && (qk_q[i] == cdb_tag)) begin
                    vk_d[i] = cdb_data;
                    qk_d[i] = '0;
                end
            end
        end

        if (release_c) begin
            busy_d[cur_q] = 1'b0;
        end

        // The allocated entry is free in busy_q, so it never collides with release or snoop
        if (issue_fire_c) begin
            busy_d[alloc_idx_c] = 1'b1;
            op_d[alloc_idx_c]   = issue_op;
            if (cdb_hit_c && (issue_qj == cdb_tag)) begin
                vj_d[alloc_idx_c] = cdb_data;
                qj_d[alloc_idx_c] = '0;
            end else begin
                vj_d[alloc_idx_c] = issue_vj;
                qj_d[alloc_idx_c] = issue_qj;
            end
            if (cdb_hit_c && (issue_qk == cdb_tag)) begin
                vk_d[alloc_idx_c] = cdb_data;
                qk_d[alloc_idx_c] = '0;
            end else begin
                vk_d[alloc_idx_c] = issue_vk;
                qk_d[alloc_idx_c] = issue_qk;
            end
        end

        if (flush_c) begin
            busy_d = '0;
        end
    end

    // Occupancy outputs, registered from the next busy vector
    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < int'(NUM_ENT); i++) begin
            busy_count_d = busy_count_d + CW'(busy_d[i]);
        end
        issue_ready_d = ~&busy_d;
    end

    // Scheduler FSM next-state and output registers
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cur_d       = cur_q;
        fu_a_d      = fu_a_q;
        fu_b_d      = fu_b_q;
        fu_op_d     = fu_op_q;
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_data_d  = res_data_q;
        release_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sel_found_c) begin
                    fu_a_d  = vj_q[sel_idx_c];
                    fu_b_d  = vk_q[sel_idx_c];
                    fu_op_d = op_q[sel_idx_c];
                    cur_d   = sel_idx_c;
                    rr_d    = sel_idx_c;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_data_d  = fu_Q;
                res_tag_d   = TW'(BASE_TAG) + TW'(cur_q);
                res_valid_d = 1'b1;
                state_d     = S_RESULT;
            end
            S_RESULT: begin
                if (res_grant) begin
                    res_valid_d = 1'b0;
                    release_c   = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush_c) begin
            state_d     = S_IDLE;
            res_valid_d = 1'b0;
            release_c   = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_q          <= '0;
            cur_q         <= '0;
            busy_q        <= '0;
            for (int i = 0; i < int'(NUM_ENT); i++) begin
                op_q[i] <= '0;
                vj_q[i] <= '0;
                vk_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
            end
            fu_a_q        <= '0;
            fu_b_q        <= '0;
            fu_op_q       <= '0;
            res_valid_q   <= 1'b0;
            res_tag_q     <= '0;
            res_data_q    <= '0;
            busy_count_q  <= '0;
            issue_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            cur_q         <= cur_d;
            busy_q        <= busy_d;
            for (int i = 0; i < int'(NUM_ENT); i++) begin
                op_q[i] <= op_d[i];
                vj_q[i] <= vj_d[i];
                vk_q[i] <= vk_d[i];
                qj_q[i] <= qj_d[i];
                qk_q[i] <= qk_d[i];
            end
            fu_a_q        <= fu_a_d;
            fu_b_q        <= fu_b_d;
            fu_op_q       <= fu_op_d;
            res_valid_q   <= res_valid_d;
            res_tag_q     <= res_tag_d;
            res_data_q    <= res_data_d;
            busy_count_q  <= busy_count_d;
            issue_ready_q <= issue_ready_d;
        end
    end

    assign issue_ready = issue_ready_q;
    assign busy_count  = busy_count_q;
    assign fu_A        = fu_a_q;
    assign fu_B        = fu_b_q;
    assign fu_op       = fu_op_q;
    assign res_valid   = res_valid_q;
    assign res_tag     = res_tag_q;
    assign res_data    = res_data_q;

endmodule

// File: tb/tb_estacao_reserva_r.sv
// tb_estacao_reserva_r
// Self-checking bench for estacao_reserva_r.
// A behavioural station model predicts each entry's result once its operands
// are known and queues it by tag. A separate monitor checks every result the
// DUT presents, and checks that held results stay stable.

module tb_estacao_reserva_r;

    localparam int unsigned BASE = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_v = 1'b0;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_op;
    logic [15:0] issue_vj, issue_vk;
    logic [2:0]  issue_qj, issue_qk;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic [15:0] fu_A, fu_B, fu_Q;
    logic [2:0]  fu_op;
    logic        res_valid;
    logic [2:0]  res_tag;
    logic [15:0] res_data;
    logic        res_grant;
    logic [1:0]  busy_count;

    always #5 clk = ~clk;

    estacao_reserva_r #(.BASE_TAG(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef RS_R_FLUSH_EN
        .flush       (flush_v),
`endif
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_vj    (issue_vj),
        .issue_vk    (issue_vk),
        .issue_qj    (issue_qj),
        .issue_qk    (issue_qk),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .fu_A        (fu_A),
        .fu_B        (fu_B),
        .fu_op       (fu_op),
        .fu_Q        (fu_Q),
        .res_valid   (res_valid),
        .res_tag     (res_tag),
        .res_data    (res_data),
        .res_grant   (res_grant),
        .busy_count  (busy_count)
    );

    // Bench-side functional unit: ops 100/101 use only B
    function automatic logic [15:0] fu_func(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'b000:  fu_func = a + b;
            3'b001:  fu_func = a - b;
            3'b010:  fu_func = a & b;
            3'b011:  fu_func = a | b;
            3'b100:  fu_func = b + 16'd4;
            3'b101:  fu_func = b >> 1;
            3'b110:  fu_func = a ^ b;
            default: fu_func = ~a;
        endcase
    endfunction

    assign fu_Q = fu_func(fu_op, fu_A, fu_B);

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  tag;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural model of station contents
    bit          m_busy   [3];
    bit          m_pushed [3];
    logic [2:0]  m_op [3];
    logic [15:0] m_vj [3];
    logic [15:0] m_vk [3];
    logic [2:0]  m_qj [3];
    logic [2:0]  m_qk [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 3; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 1'b0;
            m_pushed[i] = 1'b0;
            m_op[i] = '0; m_vj[i] = '0; m_vk[i] = '0; m_qj[i] = '0; m_qk[i] = '0;
        end
        exp_q.delete();
    endtask

    // Apply the effect of the coming clock edge to the model (inputs already driven)
    task automatic model_step();
        bit   rel;
        bit   acc;
        int   rel_idx;
        int   alloc;
        exp_t e;
        if (flush_v) begin
            model_reset();
            return;
        end
        rel     = res_valid && res_grant;
        rel_idx = int'(res_tag) - int'(BASE);
        acc     = issue_valid && (m_count() < 3);
        alloc   = -1;
        for (int i = 2; i >= 0; i--) if (!m_busy[i]) alloc = i;
        if (cdb_valid && cdb_tag != 3'd0) begin
            for (int i = 0; i < 3; i++) begin
                if (m_busy[i] && m_qj[i] == cdb_tag) begin m_vj[i] = cdb_data; m_qj[i] = 3'd0; end
                if (m_busy[i] && m_qk[i] == cdb_tag) begin m_vk[i] = cdb_data; m_qk[i] = 3'd0; end
            end
        end
        if (rel && rel_idx >= 0 && rel_idx < 3) begin
            m_busy[rel_idx]   = 1'b0;
            m_pushed[rel_idx] = 1'b0;
        end
        if (acc && alloc >= 0) begin
            m_busy[alloc] = 1'b1;
            m_op[alloc]   = issue_op;
            m_vj[alloc]   = issue_vj;
            m_qj[alloc]   = issue_qj;
            m_vk[alloc]   = issue_vk;
            m_qk[alloc]   = issue_qk;
            if (cdb_valid && cdb_tag != 3'd0 && issue_qj == cdb_tag) begin m_vj[alloc] = cdb_data; m_qj[alloc] = 3'd0; end
            if (cdb_valid && cdb_tag != 3'd0 && issue_qk == cdb_tag) begin m_vk[alloc] = cdb_data; m_qk[alloc] = 3'd0; end
        end
        for (int i = 0; i < 3; i++) begin
            if (m_busy[i] && !m_pushed[i] && m_qk[i] == 3'd0 &&
                (m_qj[i] == 3'd0 || m_op[i] == 3'b100 || m_op[i] == 3'b101)) begin
                e.tag  = 3'(int'(BASE) + i);
                e.data = fu_func(m_op[i], m_vj[i], m_vk[i]);
                exp_q.push_back(e);
                m_pushed[i] = 1'b1;
            end
        end
    endtask

    // One clock: model update, edge, then occupancy checks
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("busy_count", 32'(busy_count), 32'(m_count()));
        check("issue_ready", 32'(issue_ready), 32'(m_count() < 3));
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
        res_grant   = 1'b0;
    endtask

    task automatic do_issue(input logic [2:0] op, input logic [15:0] vj, input logic [2:0] qj,
                            input logic [15:0] vk, input logic [2:0] qk);
        issue_valid = 1'b1;
        issue_op = op; issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
        cycle();
        issue_valid = 1'b0;
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!res_valid && n < 50) begin
            cycle();
            n++;
        end
        checks++;
        if (!res_valid) begin
            errors++;
            $display("FAIL wait_result actual=timeout required=res_valid");
        end
    endtask

    task automatic grant_one();
        res_grant = 1'b1;
        cycle();
        res_grant = 1'b0;
    endtask

    // Monitor: every newly presented result must match a queued prediction
    logic        prev_rv = 1'b0;
    logic [2:0]  prev_tag = '0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin : monitor
        int idx;
        if (rst) begin
            prev_rv = 1'b0;
        end else begin
            if (res_valid && !prev_rv) begin
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (idx < 0 && exp_q[i].tag == res_tag) idx = i;
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL result_tag actual=%0d required=tag_of_a_ready_entry", res_tag);
                end else begin
                    check("result_data", 32'(res_data), 32'(exp_q[idx].data));
                    exp_q.delete(idx);
                end
            end else if (res_valid && prev_rv) begin
                check("held_tag", 32'(res_tag), 32'(prev_tag));
                check("held_data", 32'(res_data), 32'(prev_data));
            end
            prev_rv   = res_valid;
            prev_tag  = res_tag;
            prev_data = res_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=stuck required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rr_exp[3];
        rr_exp[0] = 2; rr_exp[1] = 3; rr_exp[2] = 1;
        rst = 1'b1;
        idle_inputs();
        issue_op = '0; issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
        cdb_tag = '0; cdb_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_res_tag", 32'(res_tag), 32'(0));
        check("rst_res_data", 32'(res_data), 32'(0));
        check("rst_fu_A", 32'(fu_A), 32'(0));
        check("rst_fu_B", 32'(fu_B), 32'(0));
        check("rst_fu_op", 32'(fu_op), 32'(0));
        check("rst_busy_count", 32'(busy_count), 32'(0));
        check("rst_issue_ready", 32'(issue_ready), 32'(1));
        rst = 1'b0;

        // Simple add with minimum latency
        do_issue(3'b000, 16'd5, 3'd0, 16'd7, 3'd0);
        cycle();
        check("lat_fu_op", 32'(fu_op), 32'(0));
        check("lat_fu_A", 32'(fu_A), 32'(5));
        check("lat_fu_B", 32'(fu_B), 32'(7));
        check("lat_res_valid_early", 32'(res_valid), 32'(0));
        cycle();
        check("lat_res_valid", 32'(res_valid), 32'(1));
        check("lat_res_data", 32'(res_data), 32'(12));
        check("lat_res_tag", 32'(res_tag), 32'(1));
        grant_one();
        check("lat_res_clear", 32'(res_valid), 32'(0));

        // Full station, held result, round-robin order after last dispatch of entry 0
        for (int i = 0; i < 3; i++) do_issue(3'b000, 16'(i + 1), 3'd0, 16'd0, 3'd7);
        issue_valid = 1'b1; issue_op = 3'b110; issue_qj = 3'd0; issue_qk = 3'd0;
        cycle();
        issue_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 16'd100;
        cycle();
        cdb_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_rv();
            check("rr_order", 32'(res_tag), 32'(rr_exp[k]));
            if (k == 0) repeat (3) cycle();
            grant_one();
        end

        // Operand arrives via CDB
        do_issue(3'b001, 16'hdead, 3'd5, 16'd3, 3'd0);
        repeat (3) begin
            cycle();
            check("waits_for_operand", 32'(res_valid), 32'(0));
        end
        cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'd20;
        cycle();
        cdb_valid = 1'b0;
        wait_rv();
        check("sub_result", 32'(res_data), 32'(17));
        grant_one();

        // Qj ignored for op 100; same-cycle bypass on issue
        do_issue(3'b100, 16'h1234, 3'd6, 16'd10, 3'd0);
        wait_rv();
        check("qj_ignored", 32'(res_data), 32'(14));
        grant_one();
        cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'd9;
        do_issue(3'b000, 16'd1, 3'd0, 16'h5555, 3'd4);
        cdb_valid = 1'b0;
        wait_rv();
        check("bypass", 32'(res_data), 32'(10));
        grant_one();

        // Asynchronous reset while holding a result
        do_issue(3'b000, 16'd2, 3'd0, 16'd3, 3'd0);
        wait_rv();
        cycle();
        #2 rst = 1'b1;
        #1;
        check("arst_res_valid", 32'(res_valid), 32'(0));
        check("arst_busy_count", 32'(busy_count), 32'(0));
        check("arst_issue_ready", 32'(issue_ready), 32'(1));
        @(negedge clk);
        model_reset();
        rst = 1'b0;

`ifdef RS_R_FLUSH_EN
        do_issue(3'b000, 16'd4, 3'd0, 16'd4, 3'd0);
        cycle();
        flush_v = 1'b1; issue_valid = 1'b1;
        cycle();
        flush_v = 1'b0; issue_valid = 1'b0;
        check("flush_res_valid", 32'(res_valid), 32'(0));
`endif

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_op    = 3'($urandom);
            issue_vj    = 16'($urandom);
            issue_vk    = 16'($urandom);
            issue_qj    = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            issue_qk    = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            cdb_valid   = ($urandom_range(0, 9) < 4);
            cdb_tag     = 3'($urandom);
            cdb_data    = 16'($urandom);
            res_grant   = ($urandom_range(0, 9) < 6);
            cycle();
        end

        // Drain: broadcast every tag in turn and always grant
        issue_valid = 1'b0;
        res_grant   = 1'b1;
        cdb_valid   = 1'b1;
        for (int n = 0; n < 300 && m_count() != 0; n++) begin
            cdb_tag  = 3'((n % 7) + 1);
            cdb_data = 16'($urandom);
            cycle();
        end
        idle_inputs();
        repeat (3) cycle();
        check("drained", 32'(m_count()), 32'(0));
        check("no_missing_results", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
